apb4_slave_regbank: RTL and testbench
=====================================

// Module: apb4_slave_regbank
// PURPOSE
// - Parametrised APB4 completer: a bank of DEPTH words of DATA_W bits.
// - Adds programmable wait states, PSTRB byte-lane writes, read-only words and PSLVERR.
// - Sits on the APB4 bus as the synthesizable DUT driven by the slave VIP environment.
// PARAMETERS
// - ADDR_W       8      PADDR width
// - DATA_W       32     data width; must be 8, 16 or 32
// - DEPTH        16     number of words; must satisfy DEPTH*(DATA_W/8) <= 2**ADDR_W
// - WAIT_STATES  0      PREADY-low cycles inserted in each access phase (0..15)
// - RO_MASK      '0     DEPTH bits; bit i=1 makes word i read-only
// PORTS
// - PCLK     in   1         bus clock; all state updates on rising edge
// - PRESET   in   1         asynchronous, active-high reset
// - PSEL     in   1         completer select
// - PENABLE  in   1         access phase
// - PWRITE   in   1         1=write, 0=read
// - PADDR    in   ADDR_W    byte address
// - PWDATA   in   DATA_W    write data
// - PSTRB    in   DATA_W/8  write byte strobes
// - PREADY   out  1         transfer complete
// - PRDATA   out  DATA_W    read data
// - PSLVERR  out  1         transfer error; only meaningful while PREADY=1
// BEHAVIOUR
// - Reset (async, PRESET=1): state=IDLE, wait count=0, every mem word=0.
//   PREADY=0, PRDATA=0, PSLVERR=0. Any transfer in flight is dropped with no write.
// - FSM, two states:
//   - IDLE: setup = PSEL & !PENABLE. On setup: capture PADDR, PWRITE, PWDATA, PSTRB;
//     load wcnt=WAIT_STATES; compute err; go to ACCESS.
//   - ACCESS: if !PSEL, abort to IDLE with no write. Otherwise, if wcnt!=0, decrement it.
//     If wcnt==0, the transfer completes this cycle and the FSM returns to IDLE.
// - PREADY = (state==ACCESS) & (wcnt==0) & PSEL & PENABLE.
// - Latency: setup cycle plus WAIT_STATES+1 access cycles; PREADY is high on the last one.
// - Back-to-back transfers: a new setup may occur on the cycle after completion.
// - Bus values on PADDR/PWDATA/PSTRB/PWRITE during ACCESS are ignored; captured values are used.
// - Word index = PADDR[ADDR_W-1:log2(DATA_W/8)].
// - err is set by any of:
//   - misaligned address (low byte-offset bits != 0);
//   - index >= DEPTH;
//   - write to a word with RO_MASK[index]=1.
// - PSLVERR = err & PREADY; it is 0 in every other cycle.
// - Write: on the completing edge with !err, byte lane b of mem[index] is updated iff PSTRB[b].
//   PSTRB=0 is a legal no-op.
// - Read: PRDATA is registered and loaded at the end of the setup cycle.
//   Loaded value: mem[index] if !err, else 0. It is held through ACCESS and cleared to 0
//   on return to IDLE. Writes leave PRDATA=0.
// - PSTRB is ignored on reads.
// - Protocol violation: PENABLE=1 while in IDLE is ignored; no setup is taken.
// STRUCTURE
// - Package apb4_pkg holds:
//   - typedef enum logic {IDLE, ACCESS} apb_state_e;
//   - localparams STRB_W=DATA_W/8 and OFS_W=$clog2(STRB_W);
//   - function addr_err(index, misaligned, write, ro) shared with the VIP scoreboard.
// - One sub-module, apb4_wait_counter: 4-bit load/decrement counter with a zero flag.
// - Mem array, strobe merge and FSM stay inline.
// TESTING
// - Reset: assert PRESET mid-write during wait states (WAIT_STATES=2) -> PREADY=0 at once;
//   the word reads 0 afterwards.
// - Write 0xDEADBEEF to 0x04 with PSTRB=4'b1111, then read 0x04 -> PRDATA=0xDEADBEEF,
//   PSLVERR=0.
// - Partial write 0x11223344 with PSTRB=4'b0101 over 0xDEADBEEF at 0x08 -> reads 0xDE22BE44.
// - WAIT_STATES=3: PREADY rises exactly 4 cycles after PENABLE first goes high.
//   Back-to-back read follows with no idle cycle.
// - Errors: addr 0x02 (misaligned), addr 0x40 (DEPTH=16), write to RO word 3 (RO_MASK bit3)
//   -> PSLVERR=1 with PREADY. No mem change; PRDATA=0.
// - Abort: drop PSEL during a wait state -> FSM to IDLE, PREADY never asserts, target word unchanged.

Source files
------------

// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 register bank and its verification environment.
package apb4_pkg;

  typedef enum logic {IDLE, ACCESS} apb_state_e;

  // Lane geometry for the default 32-bit bus; the bank derives its own from DATA_W.
  localparam int BUS_DATA_W = 32;
  localparam int STRB_W     = BUS_DATA_W / 8;
  localparam int OFS_W      = $clog2(STRB_W);

  // A transfer errors on a misaligned address, an index past the bank, or a write to a read-only word.
  function automatic logic addr_err(input int unsigned index,
                                    input logic        misaligned,
                                    input logic        write,
                                    input logic        ro,
                                    input int unsigned depth = 16);
    return misaligned || (index >= depth) || (write && ro);
  endfunction

endpackage

// File: rtl/apb4_wait_counter.sv
// 4-bit wait-state counter: loads on setup, counts down during the access phase, flags zero.
module apb4_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/apb4_slave_regbank.sv
// APB4 completer: DEPTH x DATA_W register bank with wait states, byte strobes,
// read-only words and PSLVERR.
module apb4_slave_regbank
  import apb4_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter int              DATA_W      = 32,
  parameter int              DEPTH       = 16,
  parameter int              WAIT_STATES = 0,
  parameter logic [DEPTH-1:0] RO_MASK    = '0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W/8-1:0]   PSTRB,
  output logic                  PREADY,
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PSLVERR
);

  localparam int LANES    = DATA_W / 8;
  localparam int OFS_BITS = $clog2(LANES);
  localparam int MEM_IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e          state;
  logic [MEM_IW-1:0]   cap_idx;
  logic                cap_write;
  logic                cap_err;
  logic [DATA_W-1:0]   cap_wdata;
  logic [LANES-1:0]    cap_strb;
  logic [DATA_W-1:0]   prdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   idx;
  logic [MEM_IW-1:0]   widx;
  logic                misaligned;
  logic                ro_hit;
  logic                err_now;
  logic                wzero;
  logic                setup;
  logic                complete;
  logic                do_write;

  // NOTE: every always_comb target is assigned on every path, so no latch can be inferred.
  always_comb begin
    idx        = PADDR >> OFS_BITS;
    widx       = idx[MEM_IW-1:0];
    misaligned = |(PADDR & ADDR_W'(LANES - 1));
    ro_hit     = RO_MASK[widx];
    err_now    = addr_err(32'(idx), misaligned, PWRITE, ro_hit, DEPTH);
  end

  assign setup    = (state == IDLE) && PSEL && !PENABLE;
  assign complete = (state == ACCESS) && PSEL && wzero;
  assign do_write = complete && cap_write && !cap_err;

  apb4_wait_counter u_wait (
    .clk      (PCLK),
    .rst      (PRESET),
    .load     (setup),
    .dec      ((state == ACCESS) && PSEL),
    .load_val (4'(WAIT_STATES)),
    .zero     (wzero)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
      prdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            cap_idx   <= widx;
            cap_write <= PWRITE;
            cap_err   <= err_now;
            cap_wdata <= PWDATA;
            cap_strb  <= PSTRB;
            prdata_q  <= (!err_now && !PWRITE) ? mem[widx] : '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Both an abort (PSEL dropped) and a completion return to IDLE with PRDATA cleared.
          if (!PSEL || wzero) begin
            prdata_q <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the bank is cleared by reset, so it stays in flops rather than mapping to a RAM macro.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < LANES; b++) begin
        if (cap_strb[b]) mem[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
      end
    end
  end

  assign PREADY  = (state == ACCESS) && wzero && PSEL && PENABLE;
  assign PRDATA  = prdata_q;
  assign PSLVERR = cap_err && PREADY;

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Self-checking bench: table-driven APB4 transfers through a scoreboard plus hand-written
// latency, abort, protocol-violation and reset sequences on two bank instances.
module tb_apb4_slave_regbank;
  import apb4_pkg::*;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              psel0, psel1, PENABLE, PWRITE;
  logic [7:0]        PADDR;
  logic [31:0]       PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic              pready0, pready1, pslverr0, pslverr1;
  logic [31:0]       prdata0, prdata1;

  always #5 PCLK = ~PCLK;

  apb4_slave_regbank #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_STATES(3),
                       .RO_MASK(16'h0008)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0));

  apb4_slave_regbank #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_STATES(2),
                       .RO_MASK(16'h0008)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel1), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(pready1), .PRDATA(prdata1), .PSLVERR(pslverr1));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic              write;
    logic [7:0]        addr;
    logic [31:0]       wdata;
    logic [STRB_W-1:0] strb;
    logic [31:0]       exp_rdata;
    logic              exp_err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic rdy(input int w);
    return (w == 0) ? pready0 : pready1;
  endfunction
  function automatic logic slverr(input int w);
    return (w == 0) ? pslverr0 : pslverr1;
  endfunction
  function automatic logic [31:0] rdata(input int w);
    return (w == 0) ? prdata0 : prdata1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_sel(input int w, input logic v);
    if (w == 0) psel0 = v;
    else        psel1 = v;
  endtask

  task automatic bus_idle();
    @(posedge PCLK); #1;
    psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0;
  endtask

  // One full transfer; bus lines are scrambled during ACCESS to prove captured values are used.
  task automatic xfer(input int w, input logic write, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [STRB_W-1:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      output int acc_cycles);
    exp_t e;
    bit   done;
    int   n;
    @(posedge PCLK); #1;
    set_sel(w, 1'b1);
    PENABLE = 1'b0; PWRITE = write; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PWRITE = ~write; PADDR = 8'($urandom);
    PWDATA = $urandom; PSTRB = STRB_W'($urandom);
    done = 0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge PCLK);
      n++;
      if (rdy(w)) begin
        done = 1;
        e = sb_q.pop_front();
        check($sformatf("rdata@%h", addr), rdata(w), e.rdata);
        check($sformatf("pslverr@%h", addr), 32'(slverr(w)), 32'(e.err));
      end else begin
        check("pslverr_wait", 32'(slverr(w)), 32'd0);
        check("rdata_hold", rdata(w), sb_q[0].rdata);
        @(posedge PCLK); #1;
      end
    end
    if (!done) begin
      check("pready_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
    acc_cycles = n;
  endtask

  int acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1; psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;

    // Vectors applied back-to-back to the 3-wait-state bank (word 3 read-only).
    vecs.push_back('{1'b1, 8'h04, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 8'h08, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 8'h08, 32'h11223344, 4'b0101, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 8'h08, 32'h0,        4'b1010, 32'hDE22BE44, 1'b0});
    vecs.push_back('{1'b1, 8'h02, 32'h99999999, 4'b1111, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 8'h02, 32'h0,        4'b0000, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 32'h0,        4'b0000, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 8'h40, 32'h77777777, 4'b1111, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 8'h40, 32'h0,        4'b0000, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 8'h0C, 32'h12345678, 4'b1111, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 8'h0C, 32'h0,        4'b0000, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 8'h10, 32'hAABBCCDD, 4'b0000, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 8'h10, 32'h0,        4'b0000, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 8'h14, 32'h55667788, 4'b1000, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 8'h14, 32'h0,        4'b0000, 32'h55000000, 1'b0});
    vecs.push_back('{1'b1, 8'h3C, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 8'h3C, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0});

    // Reset state of both instances.
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_pready0", 32'(pready0), 32'd0);
    check("reset_prdata0", prdata0, 32'd0);
    check("reset_pslverr0", 32'(pslverr0), 32'd0);
    check("reset_pready1", 32'(pready1), 32'd0);
    check("reset_prdata1", prdata1, 32'd0);
    PRESET = 1'b0;

    foreach (vecs[i]) begin
      xfer(0, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           vecs[i].exp_rdata, vecs[i].exp_err, acc);
    end
    bus_idle();

    // PENABLE high while idle must not start a transfer.
    @(posedge PCLK); #1;
    psel0 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'h0; PSTRB = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      check("penable_in_idle", 32'(pready0), 32'd0);
    end
    bus_idle();

    // Latency: PREADY on the 4th access cycle, then a back-to-back read.
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, acc);
    check("latency_ws3", 32'(acc), 32'd4);
    xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, acc);
    check("latency_b2b", 32'(acc), 32'd4);
    xfer(0, 1'b1, 8'h20, 32'h01020304, 4'hF, 32'h0, 1'b0, acc);
    bus_idle();

    // Abort a write during a wait state.
    @(posedge PCLK); #1;
    psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h20; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("abort_w_pready_wait", 32'(pready0), 32'd0);
    @(posedge PCLK); #1;
    psel0 = 1'b0; PENABLE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      check("abort_w_pready_after", 32'(pready0), 32'd0);
    end
    xfer(0, 1'b0, 8'h20, 32'h0, 4'h0, 32'h01020304, 1'b0, acc);
    bus_idle();

    // Abort a read: PRDATA held in ACCESS, cleared on return to IDLE.
    @(posedge PCLK); #1;
    psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("abort_r_hold", prdata0, 32'hDEADBEEF);
    @(posedge PCLK); #1;
    psel0 = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("abort_r_cleared", prdata0, 32'h0);
    check("abort_r_pready", 32'(pready0), 32'd0);

    // Reset mid-write on the 2-wait-state bank.
    xfer(1, 1'b1, 8'h18, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, acc);
    xfer(1, 1'b0, 8'h18, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, acc);
    check("latency_ws2", 32'(acc), 32'd3);
    @(posedge PCLK); #1;
    psel1 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h18; PWDATA = 32'h5A5A5A5A; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    #1;
    check("reset_mid_pready", 32'(pready1), 32'd0);
    check("reset_mid_prdata", prdata1, 32'h0);
    psel1 = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    xfer(1, 1'b0, 8'h18, 32'h0, 4'h0, 32'h0, 1'b0, acc);
    bus_idle();
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0, acc);
    bus_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
